restoring_divider: RTL and testbench

- Iterative unsigned restoring divider: computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock.
- Inverse datapath to the team's carry-lookahead adder and multiplier chain: it subtracts where they add.
- Sits beside the factorial multiplier as a bus-attached arithmetic slave.
- Uses a start/done handshake so the controller FSM can launch an operation and poll for completion.

---
 rtl/restoring_divider.sv | 123 ++++++++++++
 tb/tb_restoring_divider.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Iterative unsigned restoring divider with a start/done handshake, one quotient bit per clock.
// Build option: define DIV_EARLY_EXIT_EN to finish dividend<=divisor cases in one cycle.
module restoring_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_start,
  input  logic             op_clear,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             op_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;

  logic             w_accept;
  logic             w_dz;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_r_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_short_lt;
  logic             w_short_eq;

  assign w_accept = op_start && (r_state != CALC);
  assign w_dz     = (divisor == '0);

  // Trial subtract is WIDTH+1 bits so the bit shifted out of R is kept
  // (matters whenever the divisor MSB is set).
  assign w_trial  = {r_r, r_q[WIDTH-1]};
  assign w_diff   = w_trial - {1'b0, r_d};
  assign w_ge     = ~w_diff[WIDTH];
  assign w_r_next = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_q_next = {r_q[WIDTH-2:0], w_ge};

`ifdef DIV_EARLY_EXIT_EN
  assign w_short_lt = (dividend < divisor);
  assign w_short_eq = (dividend == divisor);
`else
  assign w_short_lt = 1'b0;
  assign w_short_eq = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || op_clear) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_d         <= '0;
      r_q         <= '0;
      r_r         <= '0;
      busy        <= 1'b0;
      op_done     <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            if (w_dz) begin
              r_state     <= DONE;
              busy        <= 1'b0;
              op_done     <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else if (w_short_lt || w_short_eq) begin
              r_state     <= DONE;
              busy        <= 1'b0;
              op_done     <= 1'b1;
              quotient    <= w_short_eq ? WIDTH'(1) : '0;
              remainder   <= w_short_eq ? '0 : dividend;
              div_by_zero <= 1'b0;
            end else begin
              r_state     <= CALC;
              r_d         <= divisor;
              r_q         <= dividend;
              r_r         <= '0;
              r_cnt       <= CNT_INIT;
              busy        <= 1'b1;
              op_done     <= 1'b0;
              div_by_zero <= 1'b0;
            end
          end
        end
        CALC: begin
          // op_start is ignored here; results stay frozen until the last bit lands.
          r_q   <= w_q_next;
          r_r   <= w_r_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state   <= DONE;
            busy      <= 1'b0;
            op_done   <= 1'b1;
            quotient  <= w_q_next;
            remainder <= w_r_next;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
          op_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider at WIDTH=8 with hand-computed results.
module tb_restoring_divider;

  localparam int W = 8;

`ifdef DIV_EARLY_EXIT_EN
  localparam int SHORT_LAT = 0;
`else
  localparam int SHORT_LAT = W;
`endif

  logic         clk = 1'b0;
  logic         reset, op_start, op_clear;
  logic [W-1:0] dividend, divisor;
  logic         busy, op_done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int total = 0;
  int bad   = 0;

  restoring_divider #(.WIDTH(W), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_clear(op_clear),
    .dividend(dividend), .divisor(divisor), .busy(busy), .op_done(op_done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulse op_start for one edge; returns with that edge just past.
  task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    op_start = 1'b1;
    step();
    op_start = 1'b0;
  endtask

  // Count further edges until op_done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!op_done && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input int lat, input int exp_lat,
                              input int q, input int r, input int dz);
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".done"}, op_done, 1);
    check({tag, ".q"}, quotient, q);
    check({tag, ".r"}, remainder, r);
    check({tag, ".dz"}, div_by_zero, dz);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, op_done, 0);
    check({tag, ".q"}, quotient, 0);
    check({tag, ".r"}, remainder, 0);
    check({tag, ".dz"}, div_by_zero, 0);
  endtask

  initial begin
    int n;
    reset = 1'b1; op_start = 1'b0; op_clear = 1'b0;
    dividend = '0; divisor = '0;
    step(); step();
    reset = 1'b0;
    check_cleared("reset");

    // 100/7: full-length iteration, outputs held during CALC
    start(8'd100, 8'd7);
    check("d100.busy", busy, 1);
    check("d100.qhold", quotient, 0);
    wait_done(n);
    check_result("d100", n, W, 14, 2, 0);

    // divisor MSB set exercises the wide trial subtract
    start(8'd255, 8'd128);
    wait_done(n);
    check_result("d255", n, W, 1, 127, 0);

    // divide by zero then a clean op from DONE
    start(8'd42, 8'd0);
    wait_done(n);
    check_result("dz", n, 0, 255, 42, 1);
    start(8'd42, 8'd6);
    check("d42.done_drop", op_done, 0);
    check("d42.dz_clr", div_by_zero, 0);
    check("d42.qhold", quotient, 255);
    wait_done(n);
    check_result("d42", n, W, 7, 0, 0);

    // abort on the 4th CALC cycle
    start(8'd200, 8'd3);
    step(); step(); step();
    op_clear = 1'b1;
    step();
    op_clear = 1'b0;
    check_cleared("clear");
    step();
    check("clear.idle", op_done, 0);

    // op_start pulses during CALC are ignored
    start(8'd200, 8'd3);
    step();
    dividend = 8'd5; divisor = 8'd1; op_start = 1'b1;
    step(); step();
    op_start = 1'b0;
    wait_done(n);
    check_result("d200", n, W - 3, 66, 2, 0);

    // back-to-back from DONE
    start(8'd9, 8'd4);
    check("b2b.done_drop", op_done, 0);
    check("b2b.busy", busy, 1);
    wait_done(n);
    check_result("b2b", n, W, 2, 1, 0);

    // reset mid-CALC
    start(8'd100, 8'd7);
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_cleared("rstcalc");

    // dividend <= divisor: latency depends on the build, results don't
    start(8'd5, 8'd9);
    wait_done(n);
    check_result("d5_9", n, SHORT_LAT, 0, 5, 0);
    start(8'd9, 8'd9);
    wait_done(n);
    check_result("d9_9", n, SHORT_LAT, 1, 0, 0);

    // extremes
    start(8'd255, 8'd1);
    wait_done(n);
    check_result("d255_1", n, W, 255, 0, 0);
    start(8'd250, 8'd251);
    wait_done(n);
    check_result("d250_251", n, SHORT_LAT, 0, 250, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
